// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keypad receiver: frame states, special scan
// codes and the scan-code to hex-nibble lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_st_e;

  localparam logic [7:0] BRK_CODE  = 8'hF0;
  localparam logic [7:0] EXT_CODE  = 8'hE0;
  localparam logic [7:0] BKSP_CODE = 8'h66;
  localparam logic [7:0] ESC_CODE  = 8'h76;

  // Returns {valid, nibble}; valid is clear for any code that is not a hex make code.
  function automatic logic [4:0] scan_to_hex(input logic [7:0] code);
    logic [4:0] res;
    res = 5'h00;
    case (code)
      8'h45:   res = {1'b1, 4'h0};
      8'h16:   res = {1'b1, 4'h1};
      8'h1E:   res = {1'b1, 4'h2};
      8'h26:   res = {1'b1, 4'h3};
      8'h25:   res = {1'b1, 4'h4};
      8'h2E:   res = {1'b1, 4'h5};
      8'h36:   res = {1'b1, 4'h6};
      8'h3D:   res = {1'b1, 4'h7};
      8'h3E:   res = {1'b1, 4'h8};
      8'h46:   res = {1'b1, 4'h9};
      8'h1C:   res = {1'b1, 4'hA};
      8'h32:   res = {1'b1, 4'hB};
      8'h21:   res = {1'b1, 4'hC};
      8'h23:   res = {1'b1, 4'hD};
      8'h24:   res = {1'b1, 4'hE};
      8'h2B:   res = {1'b1, 4'hF};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, glitch filter and falling-edge detector for one PS/2 line.
// With FILTER_LEN=1 it acts as a plain synchronizer with one extra register stage.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      sync_q;
  logic            filt_q;
  logic            fall_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      // Count consecutive samples that disagree with the filtered level.
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_q <= sync_q[1];
        fall_q <= filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = filt_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver that turns hex make codes into a 4-nibble digit shift register.
// Optional frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_keypad_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [15:0] digits_o,
  output logic [3:0]  digit_en_o,
  output logic        key_strobe_o,
  output logic        frame_err_o
);

  logic sample;
  logic clk_level_unused;
  logic data_lvl;
  logic data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .line_i  (ps2_clk_i),
    .level_o (clk_level_unused),
    .fall_o  (sample)
  );

  ps2_line_filter #(.FILTER_LEN(1)) u_data_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .line_i  (ps2_data_i),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  frame_st_e   state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        byte_valid_q;
  logic        frame_err_q;
  logic        tmo_q;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;
`else
  localparam int unsigned TimeoutUnused = TIMEOUT_CYCLES;
  assign tmo_q = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q        <= 1'b0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (sample) begin
        unique case (state_q)
          StIdle: begin
            if (!data_lvl) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {data_lvl, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            par_q   <= data_lvl;
            state_q <= StStop;
          end
          StStop: begin
            if (data_lvl && (^{shift_q, par_q})) byte_valid_q <= 1'b1;
            else                                 frame_err_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q <= 1'b0;
      if (state_q == StIdle || sample) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= StIdle;
        frame_err_q <= 1'b1;
        tmo_q       <= 1'b1;
        tmo_cnt_q   <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
`endif
    end
  end

  logic [15:0] digits_q;
  logic [3:0]  digit_en_q;
  logic        strobe_q;
  logic        brk_q;
  logic        ext_q;
  logic [4:0]  hex;

  assign hex = scan_to_hex(shift_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      digits_q   <= '0;
      digit_en_q <= '0;
      strobe_q   <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (tmo_q) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
      if (byte_valid_q) begin
        if (shift_q == BRK_CODE) begin
          brk_q <= 1'b1;
        end else if (shift_q == EXT_CODE) begin
          ext_q <= 1'b1;
        end else if (brk_q) begin
          // Release code: the byte after F0 never acts as a key.
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end else if (ext_q) begin
          ext_q <= 1'b0;
        end else if (hex[4]) begin
          digits_q   <= {digits_q[11:0], hex[3:0]};
          digit_en_q <= {digit_en_q[2:0], 1'b1};
          strobe_q   <= 1'b1;
        end else if (shift_q == BKSP_CODE) begin
          digits_q   <= {4'h0, digits_q[15:4]};
          digit_en_q <= {1'b0, digit_en_q[3:1]};
          strobe_q   <= 1'b1;
        end else if (shift_q == ESC_CODE) begin
          digits_q   <= '0;
          digit_en_q <= '0;
          strobe_q   <= 1'b1;
        end
      end
    end
  end

  assign digits_o     = digits_q;
  assign digit_en_o   = digit_en_q;
  assign key_strobe_o = strobe_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Self-checking bench for ps2_keypad_rx: drives PS/2 frames and compares against a
// queue-based keypad model; covers the timeout path when PS2_RX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ps2_keypad_rx;

  localparam int unsigned TmoCycles = 1000;

  logic        clk;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic        key_strobe;
  logic        frame_err;

  ps2_keypad_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TmoCycles)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .digits_o     (digits),
    .digit_en_o   (digit_en),
    .key_strobe_o (key_strobe),
    .frame_err_o  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Keypad model: queue of nibbles, index 0 is the newest digit.
  logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  logic [3:0] mq[$];
  bit m_brk = 0;
  bit m_ext = 0;
  int exp_strobes = 0;
  int exp_errs = 0;

  function automatic int hex_of(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (hex_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int h;
    h = hex_of(b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin m_brk = 0; m_ext = 0; end
    else if (m_ext) m_ext = 0;
    else if (h >= 0) begin
      mq.push_front(4'(h));
      if (mq.size() > 4) void'(mq.pop_back());
      exp_strobes++;
    end else if (b == 8'h66) begin
      if (mq.size() > 0) void'(mq.pop_front());
      exp_strobes++;
    end else if (b == 8'h76) begin
      mq.delete();
      exp_strobes++;
    end
  endfunction

  function automatic logic [15:0] model_digits();
    logic [15:0] d = '0;
    for (int i = 0; i < mq.size(); i++) d[4*i +: 4] = mq[i];
    return d;
  endfunction

  function automatic logic [3:0] model_en();
    logic [3:0] e = '0;
    for (int i = 0; i < mq.size(); i++) e[i] = 1'b1;
    return e;
  endfunction

  // Compare process: pulses are tallied every cycle, settled state checked while idle.
  bit check_en = 0;
  int obs_strobes = 0;
  int obs_errs = 0;
  int last_strobe_cyc = 0;
  int stop_fall_cyc = 0;

  always @(negedge clk) begin
    if (key_strobe === 1'b1) begin
      obs_strobes++;
      last_strobe_cyc = cyc;
    end
    if (frame_err === 1'b1) obs_errs++;
    if (check_en) begin
      chk("digits_model", 32'(digits), 32'(model_digits()));
      chk("digit_en_model", 32'(digit_en), 32'(model_en()));
      chk("strobe_count", obs_strobes, exp_strobes);
      chk("err_count", obs_errs, exp_errs);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of {stop, parity, data, start}; optional short clock glitches.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      wait_cyc(6);
      if (glitch) begin
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(11);
      end else begin
        wait_cyc(14);
      end
      ps2_clk = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      wait_cyc(20);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                           input bit glitch = 0);
    logic par;
    par = ~(^b) ^ bad_par;
    check_en = 0;
    send_bits({~bad_stop, par, b, 1'b0}, 11, glitch);
    wait_cyc(30);
    if (bad_par || bad_stop) exp_errs++;
    else model_byte(b);
    check_en = 1;
    wait_cyc(3);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_digit_en", 32'(digit_en), 32'h0);
    chk("reset_strobe", 32'(key_strobe), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    check_en = 1;
    wait_cyc(5);

    // Make, then release of the same key.
    send_byte(8'h16);
    chk("strobe_latency", last_strobe_cyc - stop_fall_cyc, 12);
    send_byte(8'hF0);
    send_byte(8'h16);
    chk("one_key_digits", 32'(digits), 32'h0001);
    chk("one_key_en", 32'(digit_en), 32'h1);
    chk("one_key_strobes", obs_strobes, 1);

    // Five keys: oldest nibble falls off.
    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'h26);
    send_byte(8'h1C);
    send_byte(8'h32);
    chk("five_keys_digits", 32'(digits), 32'h23AB);
    chk("five_keys_en", 32'(digit_en), 32'hF);
    chk("five_keys_strobes", obs_strobes, 6);

    send_byte(8'h66);
    send_byte(8'h66);
    chk("bksp_digits", 32'(digits), 32'h0023);
    chk("bksp_en", 32'(digit_en), 32'h3);
    send_byte(8'h76);
    chk("esc_digits", 32'(digits), 32'h0);
    chk("esc_en", 32'(digit_en), 32'h0);

    // Bad parity then bad stop bit.
    send_byte(8'h45, 1'b1, 1'b0);
    send_byte(8'h45, 1'b0, 1'b1);
    chk("bad_frames_errs", obs_errs, 2);
    chk("bad_frames_strobes", obs_strobes, 9);

    // Extended prefix swallows the next byte.
    send_byte(8'hE0);
    send_byte(8'h16);
    chk("ext_ignored", 32'(digits), 32'h0);
    send_byte(8'h1C);
    chk("after_ext_digits", 32'(digits), 32'h000A);

    // Glitches on the PS/2 clock during every bit.
    send_byte(8'h26, 1'b0, 1'b0, 1'b1);
    chk("glitch_digits", 32'(digits), 32'h00A3);

    // Typematic repeats, then backspace saturating at empty.
    send_byte(8'h1E);
    send_byte(8'h1E);
    chk("typematic_digits", 32'(digits), 32'hA322);
    send_byte(8'h76);
    send_byte(8'h66);
    chk("bksp_empty_en", 32'(digit_en), 32'h0);
    chk("bksp_empty_strobes", obs_strobes, 15);

    // Reset mid-frame with break pending: no error, flags cleared.
    send_byte(8'h16);
    send_byte(8'hF0);
    check_en = 0;
    send_bits({1'b1, 1'b0, 8'h1E, 1'b0}, 4, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    mq.delete();
    m_brk = 0;
    m_ext = 0;
    wait_cyc(2);
    check_en = 1;
    chk("midframe_reset_digits", 32'(digits), 32'h0);
    send_byte(8'h16);
    chk("after_reset_digits", 32'(digits), 32'h0001);
    chk("after_reset_errs", obs_errs, 2);

`ifdef PS2_RX_TIMEOUT_EN
    // Truncated frame after a break code: timeout error, break forgotten.
    send_byte(8'hF0);
    check_en = 0;
    send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5, 1'b0);
    wait_cyc(TmoCycles + 100);
    exp_errs++;
    m_brk = 0;
    m_ext = 0;
    check_en = 1;
    chk("timeout_errs", obs_errs, 3);
    send_byte(8'h45);
    chk("after_timeout_digits", 32'(digits), 32'h0010);
    chk("after_timeout_en", 32'(digit_en), 32'h3);
`endif

    check_en = 0;
    wait_cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
